// File: rtl/gf2m_serial_mult.sv
// Bit-serial multiplier over GF(2^M), polynomial basis, default f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// Computes c = a*b mod f, MSB-first shift/reduce/add over the bits of b.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   start  in   multiply request, sampled only when idle
//   a, b   in   M-bit operands, latched on an accepted start
//   busy   out  high while running and in the done cycle
//   done   out  one-cycle completion pulse; c is valid in the same cycle
//   c      out  M-bit product register, held until the next done
//
// Build option: define GF_MULT_DIGIT2_EN to process two bits of b per cycle
// (ceil(M/2) iterations instead of M). Results are identical in both builds.
module gf2m_serial_mult #(
  parameter int unsigned  M    = 163,
  parameter logic [M-1:0] POLY = {{(M-8){1'b0}}, 8'hC9}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] c
);

`ifdef GF_MULT_DIGIT2_EN
  localparam int unsigned Iter = (M + 1) / 2;
`else
  localparam int unsigned Iter = M;
`endif
  localparam int unsigned CntW = (Iter > 1) ? $clog2(Iter) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [M-1:0]    ra_q, ra_d;
  logic [M-1:0]    rb_q, rb_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [M-1:0]    c_q, c_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [M-1:0]    acc_step;

  // One MSB-first step: acc*x mod f, then add x_in if the current multiplier bit is set.
  function automatic logic [M-1:0] mul_step(input logic [M-1:0] acc,
                                            input logic [M-1:0] x_in,
                                            input logic         bit_en);
    logic [M:0] t;
    t = {acc, 1'b0};
    return t[M-1:0] ^ (t[M] ? POLY : '0) ^ (bit_en ? x_in : '0);
  endfunction

`ifdef GF_MULT_DIGIT2_EN
  // b is zero-extended so the top digit of an odd-width operand has a zero high bit.
  logic [2*Iter-1:0] rb_ext;
  logic [M-1:0]      acc_mid;

  always_comb begin
    rb_ext   = (2*Iter)'(rb_q);
    acc_mid  = mul_step(acc_q, ra_q, rb_ext[{cnt_q, 1'b1}]);
    acc_step = mul_step(acc_mid, ra_q, rb_ext[{cnt_q, 1'b0}]);
  end
`else
  always_comb begin
    acc_step = mul_step(acc_q, ra_q, rb_q[cnt_q]);
  end
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          acc_d   = '0;
          cnt_d   = CntW'(Iter - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          // Final iteration: the product goes straight into c so it is valid in the done cycle.
          c_d     = acc_step;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign c    = c_q;

endmodule

// File: tb/tb_gf2m_serial_mult.sv
module tb_gf2m_serial_mult;
  localparam int unsigned M = 163;
`ifdef GF_MULT_DIGIT2_EN
  localparam int ITER = (M + 1) / 2;
`else
  localparam int ITER = M;
`endif
  localparam int LIMIT = ITER + 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] a, b;
  logic         busy, done;
  logic [M-1:0] c;

  int total = 0;
  int bad   = 0;
  logic [M-1:0] exp_q[$];

  gf2m_serial_mult dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .c    (c)
  );

  always #5 clk = ~clk;

  // Reference: full schoolbook product, then reduce from the top bit down.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-2:0] p;
    logic [2*M-2:0] xf;
    logic [2*M-2:0] fpoly;
    p     = '0;
    xf    = '0;
    xf[M-1:0] = x;
    fpoly = '0;
    fpoly[M] = 1'b1;
    fpoly[7] = 1'b1;
    fpoly[6] = 1'b1;
    fpoly[3] = 1'b1;
    fpoly[0] = 1'b1;
    for (int i = 0; i < M; i++) if (y[i]) p ^= (xf << i);
    for (int i = 2*M-2; i >= M; i--) if (p[i]) p ^= (fpoly << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_op();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[M-1:0];
  endfunction

  // Drive operands and start at a negedge; record the expected product.
  task automatic launch(input logic [M-1:0] x, input logic [M-1:0] y);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(ref_mul(x, y));
  endtask

  // Count negedges until done is seen (bounded); optionally drop start after the first edge.
  task automatic wait_done(input bit drop_start, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_start && n == 1) start = 1'b0;
    end while (done !== 1'b1 && n < LIMIT);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (c !== '0) begin bad++; $display("FAIL reset_c got=%h want=0", c); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [M-1:0] ops_a[5];
    logic [M-1:0] ops_b[5];
    logic [M-1:0] one, top, ones, want;
    int n;
    one  = '0; one[0] = 1'b1;
    top  = '0; top[M-1] = 1'b1;
    ones = '1;
    ops_a = '{one, top, top, '0, ones};
    ops_b = '{one, M'(2), top, ones, one};
    for (int k = 0; k < 5; k++) begin
      launch(ops_a[k], ops_b[k]);
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL dir%0d_busy_c1 got=%b want=1", k, busy); end
      wait_done(1'b0, n);
      n++;
      total++;
      if (n !== ITER + 1) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, n, ITER + 1); end
      want = exp_q.pop_front();
      total++;
      if (c !== want) begin bad++; $display("FAIL dir%0d_c got=%h want=%h", k, c, want); end
      if (k == 0) begin
        total++; if (c !== one) begin bad++; $display("FAIL one_x_one got=%h want=1", c); end
      end
      if (k == 1) begin
        total++;
        if (c !== M'(8'hC9)) begin bad++; $display("FAIL x163_mod_f got=%h want=c9", c); end
      end
      if (k == 3) begin
        total++; if (c !== '0) begin bad++; $display("FAIL zero_prod got=%h want=0", c); end
      end
      if (k == 4) begin
        total++; if (c !== ones) begin bad++; $display("FAIL ones_x_one got=%h want=all-ones", c); end
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL dir%0d_after busy=%b done=%b want=0,0", k, busy, done);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [M-1:0] want;
    int n;
    launch(rand_op(), rand_op());
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (n == 10) begin
        start = 1'b1; a = rand_op(); b = rand_op();
      end
    end while (done !== 1'b1 && n < LIMIT);
    total++;
    if (n !== ITER + 1) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", n, ITER + 1); end
    want = exp_q.pop_front();
    total++;
    if (c !== want) begin bad++; $display("FAIL ign_c got=%h want=%h", c, want); end
    // Pulse start during the done cycle with fresh operands; it must not be queued.
    start = 1'b1; a = rand_op(); b = rand_op();
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL ign_busy got=%b want=0", busy); end
    total++;
    if (c !== want) begin bad++; $display("FAIL ign_c_hold got=%h want=%h", c, want); end
  endtask

  task automatic test_reset_mid();
    logic [M-1:0] want;
    int n;
    int seen;
    launch(rand_op(), rand_op());
    void'(exp_q.pop_front());
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    total++;
    if (c !== '0) begin bad++; $display("FAIL rstmid_c got=%h want=0", c); end
    seen = 0;
    for (int i = 0; i < ITER + 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", seen); end
    // Reset and start on the same edge: reset wins.
    rst = 1'b1; start = 1'b1; a = rand_op(); b = rand_op();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_busy got=%b want=0", busy); end
    launch(rand_op(), rand_op());
    wait_done(1'b1, n);
    total++;
    if (n !== ITER + 1) begin bad++; $display("FAIL rstmid_fresh_lat got=%0d want=%0d", n, ITER + 1); end
    want = exp_q.pop_front();
    total++;
    if (c !== want) begin bad++; $display("FAIL rstmid_fresh_c got=%h want=%h", c, want); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [M-1:0] x, y, want;
    int n;
    int extra;
    x = rand_op(); y = rand_op();
    launch(x, y);
    for (int i = 0; i < 200; i++) begin
      wait_done(1'b0, n);
      total++;
      if (n !== ((i == 0) ? ITER + 1 : ITER + 2)) begin
        bad++; $display("FAIL b2b%0d_spacing got=%0d want=%0d", i, n, (i == 0) ? ITER + 1 : ITER + 2);
      end
      want = exp_q.pop_front();
      total++;
      if (c !== want) begin bad++; $display("FAIL b2b%0d_c got=%h want=%h", i, c, want); end
      if (i == 199) begin
        start = 1'b0;
      end else if (i % 2 == 0) begin
        // Swapped operands must give the product of the original order.
        a = y; b = x;
        exp_q.push_back(ref_mul(x, y));
      end else begin
        x = rand_op(); y = rand_op();
        launch(x, y);
      end
    end
    extra = 0;
    for (int i = 0; i < ITER + 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL b2b_extra_done got=%0d want=0", extra); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_queue got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf2m_serial_mult.md
# gf2m_serial_mult

Bit-serial multiplier over GF(2^163) (polynomial basis, f(x) = x^163 + x^7 + x^6 + x^3 + 1) that forms the processing stage fed by the logic-analyzer operand loader. It consumes two 163-bit operand registers on a start pulse and produces the product c = a·b mod f. It signals completion with a one-cycle `done` pulse, which the loader FSM consumes to leave its processing state and enter readback.

## Interface
- `M`, 163, field degree; also the width of `a`, `b` and `c`.
- `POLY`, 163'hC9, low-order terms of f(x): bits 7, 6, 3 and 0 set. The x^M term is implicit.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  request a multiply. Sampled only in IDLE.
- `a`  in  M  multiplicand. Latched on an accepted start.
- `b`  in  M  multiplier. Latched on an accepted start.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `c` is valid in the same cycle.
- `c`  out  M  product register. Holds its value until the next `done`.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE with `start`=1:
  - Latch `a` into `ra` and `b` into `rb`.
  - Clear accumulator `acc` to 0.
  - Load iteration counter `cnt` with ITER-1.
  - Go to RUN.
- RUN, each cycle:
  - Step: `t` = {`acc`,1'b0}, width M+1.
  - Reduce: `acc` ← `t`[M-1:0] ^ (`t`[M] ? `POLY` : 0), then ^ (`rb`[`cnt`] ? `ra` : 0).
  - Processing is MSB-first.
  - `cnt` decrements each cycle. When `cnt`==0, go to DONE.
- DONE:
  - `c` ← `acc`, `done`=1. `c` and `done` are registered, so both are valid in the DONE cycle.
  - Next state is IDLE.
- `start` in RUN or DONE is ignored. It is not queued.
- `ra` and `rb` do not change in RUN. Input changes after acceptance have no effect.
- `c` is written only on entry to DONE. It keeps the last product indefinitely.
- Arithmetic is pure XOR/shift. There is no carry, and the result is always fully reduced (degree < M).
- Reset, in any state, mid-operation included:
  - State → IDLE; `busy`=0, `done`=0, `c`=0, `acc`=0, `cnt`=0.
  - The aborted operation produces no `done`.

## Timing
- Let the rising edge that samples `start` in IDLE be edge 0.
- `busy` is high from the cycle after edge 0 until the end of the DONE cycle.
- RUN occupies ITER cycles. ITER = M (163) in the default build.
- `done` is high in cycle ITER+1 after edge 0, i.e. 164 cycles in the default build. `c` is valid in the same cycle and stays valid afterward.
- Back-to-back: a `start` held high through DONE is accepted on the first IDLE cycle. Throughput is one product per ITER+2 cycles.
- `start` and `rst` on the same edge: reset wins and nothing is latched.

## Configuration
- `GF_MULT_DIGIT2_EN`:
  - Defined: two bits of `rb` are processed per RUN cycle, as two chained shift/reduce/add steps in one cycle.
    - `rb` is zero-extended to M+1 bits.
    - ITER = ceil(M/2) = 82.
    - `done` arrives 83 cycles after acceptance.
  - Undefined: one bit per cycle, ITER = M = 163.
- Results are bit-identical in both builds.

## Test plan
- a=1, b=1, start → `done` at cycle 164 (83 with `GF_MULT_DIGIT2_EN`), `c`=1, `busy` low the cycle after.
- a=1<<162, b=2 → c = x^163 mod f = 163'hC9. a=b=1<<162 → c = x^324 mod f, matching the reference software model.
- a=0, b=all-ones → c=0. a=all-ones, b=1 → c=all-ones.
- Pulse `start` again at cycles 10 and 164 (the DONE cycle) of a running operation, with different operands → both ignored; `c` equals the first product.
- Assert `rst` for one cycle at cycle 50 of an operation → `busy`=0 and `c`=0 next cycle; no `done` pulse; a fresh start then completes correctly.
- 200 random (a,b) pairs issued back-to-back, `start` held high → each `c` matches the model; a·b equals b·a; exactly one `done` per product at a spacing of ITER+2 cycles.
